// File: rtl/rc4_host_pkg.sv
// Shared types and constants for the RC4 host controller.
// Watchdog width is used only when RC4_HOST_TIMEOUT_EN is defined.
package rc4_host_pkg;

  localparam int KEY_LEN_DEF = 32;
  localparam int MSG_MAX_DEF = 64;
  localparam int DATA_W      = 8;
  localparam int LEN_W       = 7;
  localparam int WDOG_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    ENC,
    DEC,
    FIN
  } state_t;

  function automatic logic [LEN_W-1:0] sat_cnt(
    input logic [LEN_W:0] v
  );
    return v[LEN_W] ? '1 : v[LEN_W-1:0];
  endfunction

endpackage

// File: rtl/rc4_host_if.sv
// Handshake bundle between the host controller (master) and the RC4 core.
// plain_read / cipher_read are advisory strobes from the core.
interface rc4_host_if #(
  parameter int DW = rc4_host_pkg::DATA_W
);
  logic          key_valid;
  logic [DW-1:0] key_in;
  logic          plain_in_valid;
  logic [DW-1:0] plain_in;
  logic          cipher_in_valid;
  logic [DW-1:0] cipher_in;
  logic          plain_read;
  logic          cipher_write;
  logic [DW-1:0] cipher_out;
  logic          cipher_read;
  logic          plain_write;
  logic [DW-1:0] plain_out;
  logic          done;

  modport master (
    output key_valid, key_in,
    output plain_in_valid, plain_in,
    output cipher_in_valid, cipher_in,
    input  plain_read, cipher_write, cipher_out,
    input  cipher_read, plain_write, plain_out,
    input  done
  );

  modport slave (
    input  key_valid, key_in,
    input  plain_in_valid, plain_in,
    input  cipher_in_valid, cipher_in,
    output plain_read, cipher_write, cipher_out,
    output cipher_read, plain_write, plain_out,
    output done
  );
endinterface

// File: rtl/rc4_host_buf.sv
// Byte RAM: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module rc4_host_buf #(
  parameter int DEPTH = 32,
  parameter int DW    = rc4_host_pkg::DATA_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/rc4_host_ctrl.sv
// RC4 host controller: key stream, encrypt, decrypt, compare self-test.
// Define RC4_HOST_TIMEOUT_EN to add the watchdog and timeout port.
module rc4_host_ctrl #(
  parameter int KEY_LEN = rc4_host_pkg::KEY_LEN_DEF,
  parameter int MSG_MAX = rc4_host_pkg::MSG_MAX_DEF,
  parameter int DATA_W  = rc4_host_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [5:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic [6:0]        msg_len,
  input  logic              start,
  output logic              busy,
  output logic              result_valid,
  output logic              pass,
  output logic [6:0]        mismatch_cnt,
  output logic              cfg_err,
`ifdef RC4_HOST_TIMEOUT_EN
  output logic              timeout,
`endif
  rc4_host_if.master        core
);
  import rc4_host_pkg::*;

  localparam int KAW = $clog2(KEY_LEN);
  localparam int MAW = $clog2(MSG_MAX);
  localparam int KCW = $clog2(KEY_LEN + 1);
  localparam logic [KCW-1:0] KEY_LAST = KCW'(KEY_LEN);
  localparam logic [LEN_W-1:0] MSG_TOP = LEN_W'(MSG_MAX);

  state_t state, state_n;

  logic [KCW-1:0]   kcnt;
  logic [LEN_W-1:0] len, p, q, p_nx, q_nx, miss;
  logic [DATA_W-1:0] key_rd, msg_rd, cb_rd, pin;
  logic             pin_v;
  logic             len_ok, key_we, msg_we;
  logic             cap_enc, cap_dec, neq, wd_hit;
  logic [KAW-1:0]   key_ra;
  logic [MAW-1:0]   msg_ra;
  logic [LEN_W:0]   m_step, m_fin;
  logic             unused_adv;

  assign unused_adv = core.plain_read ^ core.cipher_read;

  assign len_ok = (msg_len != '0) && (msg_len <= MSG_TOP);
  assign key_we = cfg_we && !cfg_sel && (state == IDLE)
                  && (int'(cfg_addr) < KEY_LEN);
  assign msg_we = cfg_we && cfg_sel && (state == IDLE)
                  && (int'(cfg_addr) < MSG_MAX);

  assign cap_enc = (state == ENC) && core.cipher_write && (p < len);
  assign cap_dec = (state == DEC) && core.plain_write && (q < len);
  assign p_nx    = p + LEN_W'(1);
  assign q_nx    = q + LEN_W'(1);
  assign key_ra  = KAW'(kcnt - KCW'(1));
  assign msg_ra  = (state == DEC) ? q[MAW-1:0] :
                   (state == ENC) ? p_nx[MAW-1:0] : '0;

  // Missing bytes on an early done count as mismatches.
  assign neq    = core.plain_out != msg_rd;
  assign m_step = {1'b0, mismatch_cnt} + {LEN_W'(0), neq && cap_dec};
  assign miss   = len - (cap_dec ? q_nx : q);
  assign m_fin  = m_step + {1'b0, miss};

  rc4_host_buf #(.DEPTH(KEY_LEN), .DW(DATA_W)) u_key (
    .clk   (clk),
    .we    (key_we),
    .waddr (cfg_addr[KAW-1:0]),
    .wdata (cfg_wdata),
    .raddr (key_ra),
    .rdata (key_rd)
  );

  rc4_host_buf #(.DEPTH(MSG_MAX), .DW(DATA_W)) u_msg (
    .clk   (clk),
    .we    (msg_we),
    .waddr (cfg_addr[MAW-1:0]),
    .wdata (cfg_wdata),
    .raddr (msg_ra),
    .rdata (msg_rd)
  );

  rc4_host_buf #(.DEPTH(MSG_MAX), .DW(DATA_W)) u_cbuf (
    .clk   (clk),
    .we    (cap_enc),
    .waddr (p[MAW-1:0]),
    .wdata (core.cipher_out),
    .raddr (q[MAW-1:0]),
    .rdata (cb_rd)
  );

  assign busy         = state != IDLE;
  assign result_valid = state == FIN;

  assign core.key_valid = state == KEY;
  assign core.key_in    = (state == KEY && kcnt != '0)
                          ? key_rd : '0;
  assign core.plain_in_valid  = pin_v;
  assign core.plain_in        = pin;
  assign core.cipher_in_valid = (state == DEC) && (q < len);
  assign core.cipher_in       = core.cipher_in_valid ? cb_rd : '0;

`ifdef RC4_HOST_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog;

  assign wd_hit = (state == ENC || state == DEC) && (wdog == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog    <= '0;
      timeout <= 1'b0;
    end else begin
      if (cap_enc || cap_dec || state_n != state)
        wdog <= '0;
      else if (state == ENC || state == DEC)
        wdog <= wdog + WDOG_W'(1);
      if (state == IDLE && start && len_ok)
        timeout <= 1'b0;
      else if (wd_hit)
        timeout <= 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start && len_ok) state_n = KEY;
      KEY:  if (kcnt == KEY_LAST) state_n = ENC;
      ENC:  if (p == len) state_n = DEC;
      DEC:  if (core.done) state_n = FIN;
      FIN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (wd_hit) state_n = FIN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kcnt         <= '0;
      len          <= '0;
      p            <= '0;
      q            <= '0;
      pin          <= '0;
      pin_v        <= 1'b0;
      mismatch_cnt <= '0;
      pass         <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && len_ok) begin
            len          <= msg_len;
            kcnt         <= '0;
            p            <= '0;
            q            <= '0;
            mismatch_cnt <= '0;
            pass         <= 1'b0;
          end else if (start) begin
            cfg_err <= 1'b1;
          end
        end
        KEY: begin
          kcnt <= kcnt + KCW'(1);
          if (kcnt == KEY_LAST) begin
            pin   <= msg_rd;
            pin_v <= 1'b1;
          end
        end
        ENC: begin
          if (cap_enc) begin
            p     <= p_nx;
            pin   <= msg_rd;
            pin_v <= p_nx < len;
          end else if (p == len) begin
            q     <= '0;
            pin_v <= 1'b0;
          end
        end
        DEC: begin
          if (cap_dec) begin
            q            <= q_nx;
            mismatch_cnt <= sat_cnt(m_step);
          end
          if (core.done) begin
            mismatch_cnt <= sat_cnt(m_fin);
            pass         <= m_fin == '0;
          end
        end
        default: ;
      endcase
      if (wd_hit) begin
        pass  <= 1'b0;
        pin_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rc4_host_ctrl.sv
// Bench for rc4_host_ctrl: XOR-0x5A stub core with random stalls,
// checked against a byte-level model of key, message and mismatches.
module tb_rc4_host_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we, cfg_sel, start;
  logic [5:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [6:0] msg_len;
  logic       busy, result_valid, pass, cfg_err;
  logic [6:0] mismatch_cnt;
`ifdef RC4_HOST_TIMEOUT_EN
  logic       timeout;
`endif

  rc4_host_if #(.DW(8)) bus ();

  rc4_host_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_sel      (cfg_sel),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .msg_len      (msg_len),
    .start        (start),
    .busy         (busy),
    .result_valid (result_valid),
    .pass         (pass),
    .mismatch_cnt (mismatch_cnt),
    .cfg_err      (cfg_err),
`ifdef RC4_HOST_TIMEOUT_EN
    .timeout      (timeout),
`endif
    .core         (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] key_m [32];
  logic [7:0] msg_m [64];
  bit         corrupt [64];

  logic [7:0] key_q [$];
  logic [7:0] pin_q [$];
  logic [7:0] cin_q [$];
  int         key_first, key_last, rv_cnt;
  logic       got_pass, post_rv, post_busy, ab_busy;
  logic [6:0] got_mism;
  bit         expired;

  function automatic int exp_mism(input int len, input int da);
    int m;
    m = len - da;
    for (int i = 0; i < da; i++) if (corrupt[i]) m++;
    return (m > 127) ? 127 : m;
  endfunction

  task automatic cfg_write(input bit sel, input int addr,
                           input logic [7:0] d);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_addr = 6'(addr);
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic load_msg4();
    for (int i = 0; i < 4; i++) begin
      msg_m[i] = 8'(16 * (i + 1));
      cfg_write(1'b1, i, msg_m[i]);
      corrupt[i] = 1'b0;
    end
  endtask

  // Runs one session with the stub core; done after da plain writes.
  task automatic run_session(input int len, input int da,
                             input bit poke, input int abort_at);
    int cyc, nw, ne;
    bit fin, done_sent;
    key_q.delete(); pin_q.delete(); cin_q.delete();
    rv_cnt = 0; got_pass = 0; got_mism = 0; expired = 0;
    post_rv = 0; post_busy = 0; ab_busy = 1;
    key_first = -1; key_last = -1;
    cyc = 0; nw = 0; ne = 0; fin = 0; done_sent = 0;
    @(negedge clk);
    msg_len = 7'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!fin) begin
      cfg_we = 1'b0;
      bus.cipher_write = 1'b0;
      bus.plain_write = 1'b0;
      bus.done = 1'b0;
      if (abort_at >= 0 && ne == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ab_busy = busy;
        repeat (5) begin
          if (result_valid) rv_cnt++;
          @(negedge clk);
        end
        fin = 1;
      end else begin
        if (bus.key_valid) begin
          key_q.push_back(bus.key_in);
          if (key_first < 0) key_first = cyc;
          key_last = cyc;
        end
        if (poke && bus.key_valid && key_q.size() == 1) begin
          cfg_we = 1'b1;
          cfg_sel = 1'b1;
          cfg_addr = 6'd0;
          cfg_wdata = ~msg_m[0];
        end
        if (bus.plain_in_valid && $urandom_range(0, 3) != 0) begin
          pin_q.push_back(bus.plain_in);
          bus.cipher_write = 1'b1;
          bus.cipher_out = bus.plain_in ^ 8'h5A;
          ne++;
        end
        if (bus.cipher_in_valid && nw < da
            && $urandom_range(0, 3) != 0) begin
          cin_q.push_back(bus.cipher_in);
          bus.plain_write = 1'b1;
          bus.plain_out = bus.cipher_in ^ 8'h5A
                          ^ {7'd0, corrupt[nw]};
          nw++;
        end else if (nw == da && !done_sent) begin
          bus.done = 1'b1;
          done_sent = 1;
        end
        if (result_valid) begin
          rv_cnt++;
          got_pass = pass;
          got_mism = mismatch_cnt;
          @(negedge clk);
          post_rv = result_valid;
          post_busy = busy;
          fin = 1;
        end else begin
          cyc++;
          if (cyc > 4000) begin
            expired = 1;
            fin = 1;
          end
          @(negedge clk);
        end
      end
    end
    bus.cipher_write = 1'b0;
    bus.plain_write = 1'b0;
    bus.done = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy: got %b want 0", busy);
    end
    n_chk++;
    if (result_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_rv: got %b want 0", result_valid);
    end
    n_chk++;
    if (pass !== 1'b0 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags: pass %b cfg_err %b want 0 0",
               pass, cfg_err);
    end
    n_chk++;
    if (mismatch_cnt !== 7'd0) begin
      n_fail++; $display("FAIL rst_mism: got %0d want 0", mismatch_cnt);
    end
    n_chk++;
    if ({bus.key_valid, bus.plain_in_valid, bus.cipher_in_valid,
         bus.key_in} !== 11'd0) begin
      n_fail++;
      $display("FAIL rst_core: kv %b pv %b cv %b key_in %h want 0",
               bus.key_valid, bus.plain_in_valid,
               bus.cipher_in_valid, bus.key_in);
    end
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_key_stream();
    for (int i = 0; i < 32; i++) begin
      key_m[i] = 8'(i + 1);
      cfg_write(1'b0, i, key_m[i]);
    end
    cfg_write(1'b0, 32, 8'hEE);
    load_msg4();
    run_session(4, 4, 0, -1);
    n_chk++;
    if (expired) begin
      n_fail++; $display("FAIL key_bound: run got no result_valid");
    end
    n_chk++;
    if (key_q.size() != 33) begin
      n_fail++;
      $display("FAIL key_count: got %0d want 33", key_q.size());
    end
    n_chk++;
    if (key_last - key_first + 1 != 33) begin
      n_fail++;
      $display("FAIL key_span: got %0d want 33",
               key_last - key_first + 1);
    end
    if (key_q.size() == 33) begin
      for (int i = 0; i < 33; i++) begin
        n_chk++;
        if (key_q[i] !== 8'(i)) begin
          n_fail++;
          $display("FAIL key_in[%0d]: got %h want %h",
                   i, key_q[i], 8'(i));
        end
      end
    end
  endtask

  task automatic test_round_trip();
    logic [7:0] exp_cb [4];
    exp_cb = '{8'h4A, 8'h7A, 8'h6A, 8'h1A};
    load_msg4();
    run_session(4, 4, 0, -1);
    n_chk++;
    if (expired || rv_cnt != 1) begin
      n_fail++;
      $display("FAIL rt_rv: got %0d pulses want 1", rv_cnt);
    end
    n_chk++;
    if (cin_q.size() != 4) begin
      n_fail++; $display("FAIL rt_cbuf_n: got %0d want 4", cin_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (cin_q[i] !== exp_cb[i]) begin
          n_fail++;
          $display("FAIL rt_cbuf[%0d]: got %h want %h",
                   i, cin_q[i], exp_cb[i]);
        end
      end
    end
    n_chk++;
    if (got_pass !== 1'b1 || got_mism !== 7'd0) begin
      n_fail++;
      $display("FAIL rt_result: pass %b mism %0d want 1 0",
               got_pass, got_mism);
    end
    n_chk++;
    if (post_rv !== 1'b0 || post_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rt_pulse: rv %b busy %b after FIN want 0 0",
               post_rv, post_busy);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (pass !== 1'b1) begin
      n_fail++; $display("FAIL rt_hold: pass got %b want 1", pass);
    end
  endtask

  task automatic test_corruption();
    load_msg4();
    corrupt[2] = 1'b1;
    run_session(4, 4, 0, -1);
    corrupt[2] = 1'b0;
    n_chk++;
    if (expired || got_pass !== 1'b0 || got_mism !== 7'd1) begin
      n_fail++;
      $display("FAIL corrupt: pass %b mism %0d want 0 1",
               got_pass, got_mism);
    end
  endtask

  task automatic test_early_done();
    load_msg4();
    run_session(4, 2, 0, -1);
    n_chk++;
    if (expired || got_pass !== 1'b0 || got_mism !== 7'd2) begin
      n_fail++;
      $display("FAIL early_done: pass %b mism %0d want 0 2",
               got_pass, got_mism);
    end
  endtask

  task automatic test_bad_config();
    int lens [2];
    lens = '{0, 65};
    foreach (lens[k]) begin
      @(negedge clk);
      msg_len = 7'(lens[k]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_chk++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_len_%0d: cfg_err %b busy %b want 1 0",
                 lens[k], cfg_err, busy);
      end
      @(negedge clk);
      n_chk++;
      if (cfg_err !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_pulse_%0d: cfg_err %b busy %b want 0 0",
                 lens[k], cfg_err, busy);
      end
    end
    load_msg4();
    run_session(4, 4, 1, -1);
    n_chk++;
    if (pin_q.size() != 4 || pin_q[0] !== msg_m[0]) begin
      n_fail++;
      $display("FAIL busy_write: plain_in[0] %h want %h",
               (pin_q.size() > 0) ? pin_q[0] : 8'hxx, msg_m[0]);
    end
    n_chk++;
    if (expired || got_pass !== 1'b1) begin
      n_fail++; $display("FAIL busy_write_pass: got %b want 1", got_pass);
    end
  endtask

  task automatic test_reset_mid_enc();
    load_msg4();
    run_session(4, 4, 0, 2);
    n_chk++;
    if (rv_cnt != 0 || ab_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: rv %0d busy %b want 0 0", rv_cnt, ab_busy);
    end
    run_session(4, 4, 0, -1);
    n_chk++;
    if (expired || got_pass !== 1'b1 || got_mism !== 7'd0) begin
      n_fail++;
      $display("FAIL restart: pass %b mism %0d want 1 0",
               got_pass, got_mism);
    end
    n_chk++;
    if (key_q.size() != 33 || key_q[32] !== key_m[31]) begin
      n_fail++;
      $display("FAIL restart_key: n %0d last %h want 33 %h",
               key_q.size(), (key_q.size() > 0) ? key_q[$] : 8'hxx,
               key_m[31]);
    end
  endtask

  task automatic test_random();
    int len, da;
    for (int r = 0; r < 6; r++) begin
      len = (r == 0) ? 64 : (r == 1) ? 1 : int'($urandom_range(1, 64));
      da = (r % 3 == 2) ? int'($urandom_range(1, len)) : len;
      for (int i = 0; i < 32; i++) begin
        key_m[i] = 8'($urandom);
        cfg_write(1'b0, i, key_m[i]);
      end
      for (int i = 0; i < len; i++) begin
        msg_m[i] = 8'($urandom);
        cfg_write(1'b1, i, msg_m[i]);
        corrupt[i] = ($urandom_range(0, 7) == 0);
      end
      run_session(len, da, 0, -1);
      n_chk++;
      if (expired || rv_cnt != 1) begin
        n_fail++;
        $display("FAIL rnd%0d_rv: got %0d pulses want 1", r, rv_cnt);
      end
      n_chk++;
      if (key_q.size() != 33) begin
        n_fail++;
        $display("FAIL rnd%0d_keyn: got %0d want 33", r, key_q.size());
      end else begin
        for (int i = 1; i < 33; i++) begin
          n_chk++;
          if (key_q[i] !== key_m[i-1]) begin
            n_fail++;
            $display("FAIL rnd%0d_key[%0d]: got %h want %h",
                     r, i, key_q[i], key_m[i-1]);
          end
        end
      end
      n_chk++;
      if (pin_q.size() != len || cin_q.size() != da) begin
        n_fail++;
        $display("FAIL rnd%0d_counts: plain %0d cipher %0d want %0d %0d",
                 r, pin_q.size(), cin_q.size(), len, da);
      end else begin
        for (int i = 0; i < len; i++) begin
          n_chk++;
          if (pin_q[i] !== msg_m[i]) begin
            n_fail++;
            $display("FAIL rnd%0d_plain[%0d]: got %h want %h",
                     r, i, pin_q[i], msg_m[i]);
          end
        end
        for (int i = 0; i < da; i++) begin
          n_chk++;
          if (cin_q[i] !== (msg_m[i] ^ 8'h5A)) begin
            n_fail++;
            $display("FAIL rnd%0d_cbuf[%0d]: got %h want %h",
                     r, i, cin_q[i], msg_m[i] ^ 8'h5A);
          end
        end
      end
      n_chk++;
      if (int'(got_mism) != exp_mism(len, da)
          || got_pass !== (exp_mism(len, da) == 0)) begin
        n_fail++;
        $display("FAIL rnd%0d_result: mism %0d pass %b want %0d %b",
                 r, got_mism, got_pass, exp_mism(len, da),
                 exp_mism(len, da) == 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    msg_len = '0; start = 1'b0;
    bus.plain_read = 1'b0; bus.cipher_read = 1'b0;
    bus.cipher_write = 1'b0; bus.cipher_out = '0;
    bus.plain_write = 1'b0; bus.plain_out = '0;
    bus.done = 1'b0;
    test_reset();
    test_key_stream();
    test_round_trip();
    test_corruption();
    test_early_done();
    test_bad_config();
    test_reset_mid_enc();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_bound: simulation did not finish");
    $fatal(1, "global time limit");
  end

endmodule

// File: doc/rc4_host_ctrl.md
Name: rc4_host_ctrl

Overview:
- Host-side counterpart to the RC4 stream core: the responder end of the core's key/plain/cipher handshakes.
- Holds a key buffer and a message buffer, loaded by a simple config write port.
- On start, streams the key into the core, then serves plaintext bytes and captures the returned ciphertext. It then serves that ciphertext back for decryption, captures the recovered plaintext, and compares it to the original.
- Reports pass/fail and a mismatch count. Used for on-chip self-test and as the system front end for the RC4 core.

Parameters:
KEY_LEN, 32, key bytes streamed to core
MSG_MAX, 64, message buffer depth in bytes
DATA_W, 8, byte width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_we  in  1  buffer write strobe
cfg_sel  in  1  0 = key buffer, 1 = message buffer
cfg_addr  in  6  buffer byte address
cfg_wdata  in  8  write data
msg_len  in  7  message length, latched on start
start  in  1  begin run (pulse)
busy  out  1  run in progress
result_valid  out  1  one-cycle pulse at run end
pass  out  1  all bytes matched and count complete
mismatch_cnt  out  7  number of recovered bytes differing from original
cfg_err  out  1  one-cycle pulse on rejected start
key_valid  out  1  to core
key_in  out  8  to core
plain_in_valid  out  1  to core
plain_in  out  8  to core
cipher_in_valid  out  1  to core
cipher_in  out  8  to core
plain_read  in  1  from core (advisory, not required for capture)
cipher_write  in  1  from core, cipher_out valid
cipher_out  in  8  from core
cipher_read  in  1  from core (advisory)
plain_write  in  1  from core, plain_out valid
plain_out  in  8  from core
done  in  1  from core

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; pointers p, q and counters 0. Buffer contents are not cleared. Reset mid-run aborts to IDLE with no result_valid.
- IDLE:
  - cfg_we writes the selected buffer; addresses at or beyond KEY_LEN or MSG_MAX are ignored. cfg_we is ignored in every other state.
  - start with msg_len in 1..MSG_MAX latches msg_len and goes to KEY.
  - start with msg_len = 0 or > MSG_MAX pulses cfg_err and stays in IDLE.
- KEY:
  - key_valid is high for exactly KEY_LEN+1 consecutive cycles.
  - First cycle: key_in = 0x00. Cycles 1..KEY_LEN: key_in = key[0..KEY_LEN-1].
  - Then go to ENC with p = 0.
- ENC:
  - plain_in = msg[p]; plain_in_valid = (p < len). Both are registered and change only on capture.
  - When cipher_write = 1 and p < len: cbuf[p] <= cipher_out and p++.
  - cipher_write with p = len is ignored.
  - When p = len, plain_in_valid drops and the state goes to DEC with q = 0.
- DEC:
  - cipher_in = cbuf[q]; cipher_in_valid = (q < len); plain_in_valid held 0.
  - When plain_write = 1 and q < len: compare plain_out with msg[q], increment mismatch_cnt on inequality (saturates at 127), q++.
- done:
  - done = 1 in DEC moves to FIN. If q < len at that point, the missing bytes are counted as mismatches.
  - done in any other non-IDLE state is ignored.
- FIN (one cycle):
  - result_valid = 1; pass = (mismatch_cnt == 0).
  - pass and mismatch_cnt hold until the next start.
  - Return to IDLE.
- busy = 1 in KEY, ENC, DEC and FIN. start while busy is ignored; no cfg_err.
- Simultaneous cipher_write and done in ENC: the capture occurs and done is ignored.

Optional Feature:
- Macro RC4_HOST_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog clears on every capture and every state change, and increments otherwise in ENC and DEC.
  - At 0xFFFF it forces FIN with pass = 0 and asserts sticky output timeout (extra 1-bit port), cleared on start.
- Not defined: no watchdog and no timeout port; a stalled core leaves busy high indefinitely.

Decomposition:
- Package rc4_host_pkg:
  - state enum IDLE/KEY/ENC/DEC/FIN
  - KEY_LEN_DEF, MSG_MAX_DEF, DATA_W constants
  - watchdog width constant
- Sub-module rc4_host_buf: parameterised byte RAM with one sync write port and one async read port. Three instances: key, msg, cbuf.

Test Plan:
- Key stream: load key[i] = i+1, msg_len = 4, start. key_valid high 33 cycles; key_in sequence 0x00, 0x01..0x20.
- Round trip: stub core with cipher_out = plain_in ^ 0x5A and plain_out = cipher_in ^ 0x5A; msg = 0x10, 0x20, 0x30, 0x40. cbuf = 0x4A, 0x7A, 0x6A, 0x1A; result_valid pulse; pass = 1; mismatch_cnt = 0.
- Corruption: same, but stub flips bit 0 of the 3rd plain_out. pass = 0; mismatch_cnt = 1.
- Early done: stub asserts done after 2 of 4 plain_writes. mismatch_cnt = 2; pass = 0.
- Bad config: start with msg_len = 0, then msg_len = 65. cfg_err pulses twice; busy stays 0. cfg_we during busy leaves msg unchanged.
- Reset mid-ENC at p = 2, then restart. Run completes correctly; buffers retained; no result_valid from the aborted run.
